// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-port register file with byte enables, bypass and collision flag
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst_n    in   asynchronous active-low reset; clears every register and wr_coll
//   wr       in   [NR_WR]          write enable per write port
//   addr3    in   [NR_WR*ADDR_W]   write address, port k at [k*ADDR_W +: ADDR_W]
//   data3    in   [NR_WR*DATA_W]   write data, port k at [k*DATA_W +: DATA_W]
//   be3      in   [NR_WR*DATA_W/8] byte-lane enables, port k lane b at [k*DATA_W/8 + b]
//   addr_rd  in   [NR_RD*ADDR_W]   read address, port j at [j*ADDR_W +: ADDR_W]
//   rdout    out  [NR_RD*DATA_W]   combinational read data, port j at [j*DATA_W +: DATA_W]
//   wr_coll  out  registered pulse: two or more write ports shared an address last cycle
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NR_RD    = 2,
    parameter int NR_WR    = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NR_WR-1:0]           wr,
    input  logic [NR_WR*ADDR_W-1:0]    addr3,
    input  logic [NR_WR*DATA_W-1:0]    data3,
    input  logic [NR_WR*DATA_W/8-1:0]  be3,
    input  logic [NR_RD*ADDR_W-1:0]    addr_rd,
    output logic [NR_RD*DATA_W-1:0]    rdout,
    output logic                       wr_coll
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_coll_q;
    logic              wr_coll_d;

    // Next-state image of the whole file. Ports are applied in ascending
    // order so the highest-index enabled port wins each byte lane.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (!(ZERO_REG != 0 && i == 0)) begin
                for (int k = 0; k < NR_WR; k++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr[k] && (addr3[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) && be3[k*NB + b]) begin
                            regs_d[i][8*b +: 8] = data3[k*DATA_W + 8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Collision compares raw addresses only; byte enables and the zero
    // register do not mask it.
    always_comb begin
        wr_coll_d = 1'b0;
        for (int k = 0; k < NR_WR; k++) begin
            for (int l = k + 1; l < NR_WR; l++) begin
                if (wr[k] && wr[l] && (addr3[k*ADDR_W +: ADDR_W] == addr3[l*ADDR_W +: ADDR_W])) begin
                    wr_coll_d = 1'b1;
                end
            end
        end
    end

    // Bypass reads the next-state image; it is suppressed while in reset
    // because writes presented during reset never land.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        rdout = '0;
        ra    = '0;
        for (int j = 0; j < NR_RD; j++) begin
            ra = addr_rd[j*ADDR_W +: ADDR_W];
            if (ZERO_REG != 0 && ra == '0) begin
                rdout[j*DATA_W +: DATA_W] = '0;
            end else if (BYPASS != 0 && rst_n) begin
                rdout[j*DATA_W +: DATA_W] = regs_d[ra];
            end else begin
                rdout[j*DATA_W +: DATA_W] = regs_q[ra];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_coll_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_coll_q <= wr_coll_d;
        end
    end

    assign wr_coll = wr_coll_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized and directed bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NW-1:0]     wr = '0;
    logic [NW*AW-1:0]  addr3 = '0;
    logic [NW*DW-1:0]  data3 = '0;
    logic [NW*4-1:0]   be3 = '0;
    logic [NR*AW-1:0]  addr_rd = '0;
    logic [NR*DW-1:0]  rdout_b;
    logic [NR*DW-1:0]  rdout_n;
    logic              coll_b;
    logic              coll_n;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    // mem[1]: bypass + zero-register build; mem[0]: no bypass, r0 ordinary
    logic [31:0] mem [2][32];
    logic        exp_coll;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NR_RD(NR), .NR_WR(NW), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .addr3(addr3), .data3(data3), .be3(be3),
        .addr_rd(addr_rd), .rdout(rdout_b), .wr_coll(coll_b)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NR_RD(NR), .NR_WR(NW), .BYPASS(0), .ZERO_REG(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr(wr), .addr3(addr3), .data3(data3), .be3(be3),
        .addr_rd(addr_rd), .rdout(rdout_n), .wr_coll(coll_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Which port owns lane b of address a this cycle, or -1.
    function automatic int winner(input int a, input int b);
        for (int k = NW - 1; k >= 0; k--) begin
            if (wr[k] && int'(addr3[k*AW +: AW]) == a && be3[k*4 + b]) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input int cfg, input int a);
        logic [31:0] v;
        int w;
        if (cfg == 1 && a == 0) return 32'h0;
        v = mem[cfg][a];
        if (cfg == 1 && rst_n) begin
            for (int b = 0; b < 4; b++) begin
                w = winner(a, b);
                if (w >= 0) v[8*b +: 8] = data3[w*DW + 8*b +: 8];
            end
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 32; a++) mem[c][a] = 32'h0;
            exp_coll = 1'b0;
        end else begin
            int cnt [32];
            int w;
            for (int a = 0; a < 32; a++) cnt[a] = 0;
            for (int k = 0; k < NW; k++) if (wr[k]) cnt[addr3[k*AW +: AW]]++;
            exp_coll = 1'b0;
            for (int a = 0; a < 32; a++) if (cnt[a] >= 2) exp_coll = 1'b1;
            for (int a = 0; a < 32; a++) begin
                for (int b = 0; b < 4; b++) begin
                    w = winner(a, b);
                    if (w >= 0) begin
                        mem[0][a][8*b +: 8] = data3[w*DW + 8*b +: 8];
                        if (a != 0) mem[1][a][8*b +: 8] = data3[w*DW + 8*b +: 8];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int j = 0; j < NR; j++) begin
                int a;
                a = int'(addr_rd[j*AW +: AW]);
                chk($sformatf("byp_rd%0d_r%0d", j, a), rdout_b[j*DW +: DW], model_read(1, a));
                chk($sformatf("nob_rd%0d_r%0d", j, a), rdout_n[j*DW +: DW], model_read(0, a));
            end
            chk("byp_coll", {31'b0, coll_b}, {31'b0, exp_coll});
            chk("nob_coll", {31'b0, coll_n}, {31'b0, exp_coll});
        end
    end

    task automatic setw(input int k, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr[k] = 1'b1;
        addr3[k*AW +: AW] = a;
        data3[k*DW +: DW] = d;
        be3[k*4 +: 4] = be;
    endtask

    task automatic setr(input int j, input logic [4:0] a);
        addr_rd[j*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        run = 1'b1;

        // reset with a write presented
        setw(0, 5'd10, 32'h0000FFFF, 4'hF);
        setr(0, 5'd10); setr(1, 5'd10);
        @(negedge clk);
        chk("rst_byp_rd0", rdout_b[0 +: DW], 32'h0);
        chk("rst_nob_rd1", rdout_n[DW +: DW], 32'h0);
        chk("rst_coll", {31'b0, coll_b}, 32'h0);
        step(); step();
        wr = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_r10", rdout_b[0 +: DW], 32'h0);
        chk("post_rst_r10_nb", rdout_n[0 +: DW], 32'h0);

        // basic
        step();
        setw(0, 5'd10, 32'h0000FFFF, 4'hF);
        step();
        wr = '0;
        setr(0, 5'd10);
        @(negedge clk);
        chk("basic_r10", rdout_b[0 +: DW], 32'h0000FFFF);
        step();
        setw(0, 5'd14, 32'h0000FF00, 4'hF);
        setw(1, 5'd31, 32'h0000AAAA, 4'hF);
        step();
        wr = '0;
        setr(0, 5'd31); setr(1, 5'd10);
        @(negedge clk);
        chk("basic_rd0_r31", rdout_b[0 +: DW], 32'h0000AAAA);
        chk("basic_rd1_r10", rdout_b[DW +: DW], 32'h0000FFFF);

        // bypass vs no bypass
        step();
        setw(0, 5'd14, 32'h00008888, 4'hF);
        setr(0, 5'd14);
        @(negedge clk);
        chk("bypass_same", rdout_b[0 +: DW], 32'h00008888);
        chk("nobypass_same", rdout_n[0 +: DW], 32'h0000FF00);
        step();
        wr = '0;
        @(negedge clk);
        chk("nobypass_next", rdout_n[0 +: DW], 32'h00008888);

        // byte enables
        step();
        setw(0, 5'd5, 32'h11223344, 4'hF);
        step();
        setw(0, 5'd5, 32'hAABBCCDD, 4'b0101);
        step();
        wr = '0;
        setr(0, 5'd5);
        @(negedge clk);
        chk("be_r5", rdout_b[0 +: DW], 32'h11BB33DD);
        chk("be_r5_nb", rdout_n[0 +: DW], 32'h11BB33DD);
        chk("model_r5", mem[1][5], 32'h11BB33DD);

        // collisions
        step();
        setw(0, 5'd7, 32'h00000001, 4'hF);
        setw(1, 5'd7, 32'h00000002, 4'hF);
        step();
        wr = '0;
        setr(0, 5'd7);
        @(negedge clk);
        chk("coll_r7", rdout_b[0 +: DW], 32'h00000002);
        chk("coll_pulse", {31'b0, coll_b}, 32'h1);
        step();
        @(negedge clk);
        chk("coll_clear", {31'b0, coll_b}, 32'h0);
        step();
        setw(0, 5'd7, 32'h000000AA, 4'h1);
        setw(1, 5'd7, 32'h0000BB00, 4'h2);
        step();
        wr = '0;
        @(negedge clk);
        chk("coll_merge_r7", rdout_b[0 +: DW], 32'h0000BBAA);
        chk("coll_merge_flag", {31'b0, coll_n}, 32'h1);
        chk("model_r7", mem[0][7], 32'h0000BBAA);

        // zero register
        step();
        setw(0, 5'd0, 32'hDEADBEEF, 4'hF);
        setr(0, 5'd0);
        @(negedge clk);
        chk("zero_bypass", rdout_b[0 +: DW], 32'h0);
        step();
        wr = '0;
        @(negedge clk);
        chk("zero_r0", rdout_b[0 +: DW], 32'h0);
        chk("nozero_r0", rdout_n[0 +: DW], 32'hDEADBEEF);

        // async reset in the middle of a write burst
        step();
        setw(0, 5'd3, 32'h12345678, 4'hF);
        setw(1, 5'd9, 32'h9ABCDEF0, 4'hF);
        step();
        setr(0, 5'd3); setr(1, 5'd9);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_r3", rdout_b[0 +: DW], 32'h0);
        chk("midrst_r9_nb", rdout_n[DW +: DW], 32'h0);
        step();
        wr = '0;
        rst_n = 1'b1;

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            step();
            rst_n = 1'b1;
            for (int k = 0; k < NW; k++) begin
                wr[k] = ($urandom % 3) != 0;
                addr3[k*AW +: AW] = ($urandom % 2 != 0) ? 5'($urandom % 4) : 5'($urandom % 32);
                data3[k*DW +: DW] = $urandom;
                be3[k*4 +: 4] = 4'($urandom % 16);
            end
            for (int j = 0; j < NR; j++) begin
                addr_rd[j*AW +: AW] = ($urandom % 2 != 0) ? 5'($urandom % 4) : 5'($urandom % 32);
            end
            if ($urandom % 60 == 0) begin
                #2;
                rst_n = 1'b0;
            end
        end

        step();
        rst_n = 1'b1;
        wr = '0;
        step();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
